// File: rtl/timer_pkg.sv
// Shared types and constants for the battle-turn countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_t;

  typedef logic [3:0] bcd_t;

  localparam int MAX_SEC_C     = 99;
  localparam int DEFAULT_SEC_C = 10;

endpackage

// File: rtl/tick_sync.sv
// Three-flop synchronizer for a slow divided clock, plus rising-edge detect
// producing a registered one-cycle tick in the sampling clock domain.
module tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic tick
);

  logic s1, s2, s3;

  // Flops reset high so a level already high out of reset never ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      s3   <= 1'b1;
      tick <= 1'b0;
    end else begin
      s1   <= async_in;
      s2   <= s1;
      s3   <= s2;
      tick <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/turn_timer.sv
// Battle-turn countdown timer: loads a duration in seconds and counts it down
// to 00.0 in BCD (tens, ones, tenths) on synchronized 10 Hz ticks.
module turn_timer
  import timer_pkg::*;
#(
  parameter int DEFAULT_SEC = DEFAULT_SEC_C,
  parameter int MAX_SEC     = MAX_SEC_C
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_10hz,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic [6:0] duration,
  output logic       running,
  output logic       expired,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] tenths,
  output logic       tick_10hz,
  output logic [1:0] state_dbg
);

  timer_state_t state_q, state_d;
  bcd_t tens_q, ones_q, tenths_q;
  bcd_t tens_d, ones_d, tenths_d;
  logic expired_q, expired_d;

  tick_sync u_tick_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (clk_10hz),
    .tick     (tick_10hz)
  );

  // Load value: clamp, substitute the default for zero, split into BCD.
  logic [6:0] clamp_sec, load_sec;
  bcd_t       load_tens, load_ones;

  always_comb begin
    clamp_sec = (duration > 7'(MAX_SEC)) ? 7'(MAX_SEC) : duration;
    load_sec  = (clamp_sec == 7'd0) ? 7'(DEFAULT_SEC) : clamp_sec;
    load_tens = 4'(load_sec / 7'd10);
    load_ones = 4'(load_sec % 7'd10);
  end

  // One-tenth BCD decrement with borrow chain tenths -> ones -> tens.
  bcd_t dec_tens, dec_ones, dec_tenths;
  logic dec_zero;

  always_comb begin
    dec_tens   = tens_q;
    dec_ones   = ones_q;
    dec_tenths = tenths_q - 4'd1;
    if (tenths_q == 4'd0) begin
      dec_tenths = 4'd9;
      if (ones_q == 4'd0) begin
        dec_ones = 4'd9;
        dec_tens = tens_q - 4'd1;
      end else begin
        dec_ones = ones_q - 4'd1;
      end
    end
    dec_zero = (dec_tens == 4'd0) && (dec_ones == 4'd0) && (dec_tenths == 4'd0);
  end

  // Event priority: abort, then start, then pause, then tick.
  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    tenths_d  = tenths_q;
    expired_d = 1'b0;
    if (abort) begin
      state_d  = IDLE;
      tens_d   = 4'd0;
      ones_d   = 4'd0;
      tenths_d = 4'd0;
    end else if (start) begin
      state_d  = RUN;
      tens_d   = load_tens;
      ones_d   = load_ones;
      tenths_d = 4'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (tick_10hz) begin
            tens_d   = dec_tens;
            ones_d   = dec_ones;
            tenths_d = dec_tenths;
            if (dec_zero) begin
              state_d   = DONE;
              expired_d = 1'b1;
            end
          end
        end
        PAUSED: begin
          if (!pause) state_d = RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      tenths_q  <= 4'd0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      tenths_q  <= tenths_d;
      expired_q <= expired_d;
    end
  end

  assign running   = (state_q == RUN);
  assign expired   = expired_q;
  assign sec_tens  = tens_q;
  assign sec_ones  = ones_q;
  assign tenths    = tenths_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_turn_timer.sv
// Directed bench for turn_timer: a remaining-time model in tenths of a second
// is checked every cycle, with literal expectations pinning key points.
module tb_turn_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_10hz = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [6:0] duration = 7'd0;
  logic       running, expired, tick_10hz;
  logic [3:0] sec_tens, sec_ones, tenths;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_err = 0;
  int exp_cnt = 0;

  // Model: state code 0 idle, 1 run, 2 paused, 3 done; remaining time in tenths.
  int m_state, m_rem, m_exp, m_tick;
  int p1, p2, p3;

  turn_timer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_10hz  (clk_10hz),
    .start     (start),
    .pause     (pause),
    .abort     (abort),
    .duration  (duration),
    .running   (running),
    .expired   (expired),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .tenths    (tenths),
    .tick_10hz (tick_10hz),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic int load_secs(input int d);
    int s;
    s = (d > 99) ? 99 : d;
    if (s == 0) s = 10;
    return s;
  endfunction

  function automatic int model_digits();
    return ((m_rem / 100) << 8) | (((m_rem / 10) % 10) << 4) | (m_rem % 10);
  endfunction

  function automatic int dut_digits();
    return {20'd0, sec_tens, sec_ones, tenths};
  endfunction

  task automatic model_reset();
    m_state = 0; m_rem = 0; m_exp = 0; m_tick = 0;
    p1 = 1; p2 = 1; p3 = 1;
  endtask

  task automatic model_step();
    m_exp = 0;
    if (abort) begin
      m_state = 0; m_rem = 0;
    end else if (start) begin
      m_state = 1; m_rem = load_secs(int'(duration)) * 10;
    end else if (m_state == 1) begin
      if (pause) m_state = 2;
      else if (m_tick == 1) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin m_state = 3; m_exp = 1; end
      end
    end else if (m_state == 2 && !pause) begin
      m_state = 1;
    end
    // Tick is visible two edges after the first high sample, following a low one.
    m_tick = (p2 == 1 && p3 == 0) ? 1 : 0;
    p3 = p2; p2 = p1; p1 = int'(clk_10hz);
  endtask

  // ---------------- scoreboard / compare ----------------
  task automatic compare_cycle();
    int dd, md;
    dd = dut_digits();
    md = model_digits();
    n_checks++;
    if (running !== (m_state == 1) || expired !== m_exp[0] || dd != md ||
        tick_10hz !== m_tick[0] || int'(state_dbg) != m_state) begin
      n_err++;
      $display("FAIL cycle t=%0t dut run=%0b exp=%0b dig=%03h tick=%0b st=%0d model run=%0b exp=%0d dig=%03h tick=%0d st=%0d",
               $time, running, expired, dd, tick_10hz, state_dbg,
               (m_state == 1), m_exp, md, m_tick, m_state);
    end
    if (expired === 1'b1) exp_cnt++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
      #1;
      compare_cycle();
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_10hz();
    clk_10hz = 1'b0; cyc(4);
    clk_10hz = 1'b1; cyc(4);
  endtask

  // kind: 0 plain, 1 start with dur, 2 pause, all coincident with the tick.
  task automatic hit(input int kind, input logic [6:0] dur);
    clk_10hz = 1'b0; cyc(4);
    clk_10hz = 1'b1; cyc(3);
    chk("tick_at_rise_plus3", int'(tick_10hz), 1);
    if (kind == 1) begin duration = dur; start = 1'b1; end
    if (kind == 2) pause = 1'b1;
    cyc(1);
    start = 1'b0; pause = 1'b0;
    chk("tick_width", int'(tick_10hz), 0);
    cyc(2);
  endtask

  task automatic do_start(input logic [6:0] dur);
    duration = dur; start = 1'b1; cyc(1); start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_before;
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    chk("no_tick_high_level", int'(tick_10hz), 0);
    chk("reset_digits", dut_digits(), 'h000);
    chk("reset_state", int'(state_dbg), 0);
    hit(0, 7'd0);

    // Full countdown from 3 s.
    do_start(7'd3);
    chk("load_3", dut_digits(), 'h030);
    chk("running_3", int'(running), 1);
    exp_before = exp_cnt;
    repeat (30) pulse_10hz();
    chk("done_digits", dut_digits(), 'h000);
    chk("done_running", int'(running), 0);
    chk("done_state", int'(state_dbg), 3);
    chk("expired_once", exp_cnt - exp_before, 1);
    repeat (5) pulse_10hz();
    chk("done_hold", dut_digits(), 'h000);
    chk("no_repulse", exp_cnt - exp_before, 1);

    // Default, borrow and clamp.
    do_start(7'd0);
    chk("load_default", dut_digits(), 'h100);
    pulse_10hz();
    chk("borrow", dut_digits(), 'h099);
    do_start(7'd120);
    chk("load_clamp", dut_digits(), 'h990);

    // Pause.
    do_start(7'd5);
    repeat (3) pulse_10hz();
    chk("pre_pause", dut_digits(), 'h047);
    pause = 1'b1;
    repeat (7) pulse_10hz();
    chk("paused_frozen", dut_digits(), 'h047);
    chk("paused_state", int'(state_dbg), 2);
    pause = 1'b0;
    cyc(1);
    pulse_10hz();
    chk("resume", dut_digits(), 'h046);
    hit(2, 7'd0);
    chk("pause_drops_tick", dut_digits(), 'h046);
    pulse_10hz();
    chk("after_pause_hit", dut_digits(), 'h045);

    // Start and abort together.
    duration = 7'd9; start = 1'b1; abort = 1'b1;
    cyc(1);
    start = 1'b0; abort = 1'b0;
    chk("abort_wins_digits", dut_digits(), 'h000);
    chk("abort_wins_state", int'(state_dbg), 0);

    // Start coincident with tick.
    do_start(7'd7);
    pulse_10hz();
    chk("run_7", dut_digits(), 'h069);
    hit(1, 7'd4);
    chk("start_drops_tick", dut_digits(), 'h040);
    chk("start_running", int'(running), 1);

    // Reset mid-run.
    do_start(7'd5);
    repeat (3) pulse_10hz();
    chk("pre_reset", dut_digits(), 'h047);
    exp_before = exp_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_digits", dut_digits(), 'h000);
    chk("rst_running", int'(running), 0);
    chk("rst_expired", int'(expired), 0);
    chk("rst_tick", int'(tick_10hz), 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    chk("rst_no_expire", exp_cnt - exp_before, 0);
    do_start(7'd2);
    chk("load_after_rst", dut_digits(), 'h020);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/turn_timer.md
# turn_timer

Battle-turn countdown timer for the game datapath. Consumes the divided `clk_10hz` output of the clock-divider chain, converts it into a single-cycle tick in the system clock domain, and counts a loaded duration down to 00.0 in BCD (tens, ones, tenths). Sits between the clock divider and the game FSM / HUD renderer. It drives the on-screen timer digits and signals turn expiry.

## Interface
Parameters:
- `DEFAULT_SEC`, 10: duration loaded when `duration` is 0.
- `MAX_SEC`, 99: clamp for `duration`.

Ports:
- `clk`  in  1  system clock; sole clock of the block.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `clk_10hz`  in  1  divided clock from the divider; treated as asynchronous data, never used as a clock.
- `start`  in  1  one-cycle pulse; load duration and run.
- `pause`  in  1  level; while high in RUN, the count is frozen.
- `abort`  in  1  one-cycle pulse; return to IDLE and clear the count.
- `duration`  in  7  seconds to load, binary.
- `running`  out  1  high in RUN.
- `expired`  out  1  one-cycle pulse when the count reaches 00.0.
- `sec_tens`, `sec_ones`, `tenths`  out  4 each  BCD count.
- `tick_10hz`  out  1  synchronized one-cycle tick, also provided for other consumers.

## Operation
- Synchronizer: 3-flop chain s1→s2→s3 on `clk_10hz`, all reset to 1. `tick_10hz` is registered `s2 & ~s3`. A level that is high out of reset produces no tick; the input must be seen low first.
- States:
  - IDLE: count 00.0.
  - RUN
  - PAUSED
  - DONE: count held at 00.0.
- Priority each cycle: `abort` > `start` > `pause` > tick.
- `abort` in any state → IDLE, count 00.0.
- `start` in any state → load, RUN.
  - Load value: `duration` clamped to `MAX_SEC`; 0 maps to `DEFAULT_SEC`.
  - Converted to BCD tens/ones; tenths = 0.
- RUN + `pause` → PAUSED. PAUSED + `!pause` → RUN. Ticks are ignored in PAUSED.
- RUN + tick, no higher-priority event: BCD decrement.
  - tenths 0 → 9 with ones borrow; ones 0 → 9 with tens borrow.
  - When the result is 00.0 → DONE and `expired` = 1 for that one cycle.
- DONE stays until `start` or `abort`. `expired` never re-pulses in DONE.
- Reset mid-operation: all state is discarded immediately; no `expired` pulse.

## Timing
- Reset values:
  - `running` 0, `expired` 0, all digits 0, `tick_10hz` 0, state IDLE.
- `clk_10hz` rising edge, first sampled high at clk edge N → `tick_10hz` high after edge N+2, for exactly 1 cycle.
- Tick to digit update: the decrement is registered on the edge following the `tick_10hz` cycle (1 cycle).
- `start` sampled at edge N → digits loaded and `running` = 1 after edge N.
- 00.1 → 00.0 decrement, the DONE transition and `expired` assertion all occur on the same edge. `running` falls on that edge.
- A tick coincident with `start`, `abort` or `pause` is dropped, not deferred.
- Minimum `clk` to `clk_10hz` ratio: 8.

## Structure
- Package `timer_pkg`:
  - state enum `timer_state_t` {IDLE, RUN, PAUSED, DONE}
  - `bcd_t` (4-bit)
  - `MAX_SEC_C` = 99
- Sub-module `tick_sync`: 3-flop synchronizer plus edge detect, producing `tick_10hz`. It is reusable for `clk_1hz` consumers.
- Remaining logic in `turn_timer`:
  - FSM
  - clamp and binary-to-BCD load (divide/modulo by 10 on 7 bits, combinational)
  - BCD down-counter

## Test plan
- Reset, `clk_10hz` held high, no start → no `tick_10hz` and no digit change. Then toggle `clk_10hz` → 1-cycle tick 3 edges after the rise.
- `start`, `duration`=3 → digits 3.0. After 30 ticks: 00.0, `expired` pulses once, `running` = 0, state DONE, and the digits stay 00.0 through 5 further ticks.
- `duration`=0 → 10.0 loaded. `duration`=120 → 99.0 loaded. Borrow check: from 10.0, one tick → 09.9.
- `pause` high for 7 ticks mid-run → digits frozen. Release → decrement resumes on the next tick. `pause` coincident with a tick → that tick is dropped.
- `start` and `abort` in the same cycle during RUN → IDLE, 00.0. `start` coincident with a tick → loaded value shown, not decremented.
- Assert `rst_n` low mid-run at 04.7 → all outputs 0 immediately and no `expired` pulse. After release, `start` with `duration`=2 → 02.0.
